bus_src_mux: RTL and testbench
==============================

BUS_SRC_MUX -- requirements
Module: bus_src_mux

Interface
REQ-001 SHALL have parameter DATA_W, default 16, bus data width in bits.
REQ-002 SHALL have parameter NUM_SRC, default 5, number of source registers (code 0=AC, 1=AR, 2=PC, 3=DR, 4=TR).
REQ-003 SHALL have parameter SEL_W, default 3, select code width; NUM_SRC <= 2**SEL_W.
REQ-004 SHALL have parameter END_CODE, default 6, select code that ends operations; END_CODE >= NUM_SRC.
REQ-005 SHALL have parameter CNT_W, default 8, error counter width.
REQ-006 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port sel_valid  in  1  select presented this cycle.
REQ-009 SHALL have port select  in  SEL_W  source code.
REQ-010 SHALL have port src_bus  in  NUM_SRC*DATA_W  packed sources, source k at bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have port resume  in  1  leaves HALT.
REQ-012 SHALL have port bus_out  out  DATA_W  registered bus A value.
REQ-013 SHALL have port bus_valid  out  1  one-cycle pulse, bus_out newly loaded.
REQ-014 SHALL have port end_ops  out  1  high while in HALT.
REQ-015 SHALL have port sel_err  out  1  one-cycle pulse on illegal select.
REQ-016 SHALL have port err_count  out  CNT_W  saturating illegal-select count.

Function
REQ-017 SHALL implement two states, RUN and HALT; end_ops = (state == HALT).
REQ-018 In RUN with sel_valid=1 and select < NUM_SRC, SHALL load bus_out with source[select] sampled that edge and pulse bus_valid the next cycle (latency 1).
REQ-019 In RUN with sel_valid=1 and select == END_CODE, SHALL go to HALT next cycle, leave bus_out unchanged, bus_valid=0, sel_err=0.
REQ-020 In RUN with sel_valid=1 and select neither < NUM_SRC nor END_CODE, SHALL load bus_out with 0, pulse bus_valid and sel_err for one cycle, and increment err_count.
REQ-021 err_count SHALL saturate at 2**CNT_W-1 and never wrap.
REQ-022 With sel_valid=0, bus_out SHALL hold its value and bus_valid, sel_err SHALL be 0.
REQ-023 In HALT, sel_valid SHALL be ignored entirely (no load, no error, no count).
REQ-024 In HALT with resume=1, SHALL return to RUN next cycle; sel_valid in that same cycle is ignored.
REQ-025 resume in RUN SHALL have no effect.
REQ-026 Source changes without sel_valid SHALL not affect bus_out.

Reset
REQ-027 rst=1 at a rising edge SHALL force state=RUN, bus_out=0, bus_valid=0, sel_err=0, err_count=0, overriding all other inputs, including mid-HALT and in the same cycle as sel_valid.
REQ-028 The first cycle after rst deasserts SHALL accept sel_valid normally.

Structure
REQ-029 Source codes (AC..TR), END_CODE default, and the RUN/HALT state encoding SHALL live in shared package bus_pkg.
REQ-030 The saturating counter SHALL be sub-module bus_err_counter (ports clk, rst, inc, count).
REQ-031 Source selection SHALL be a single indexed part-select; no latches.

Verification
REQ-032 Reset then sel_valid=1, select=2, PC=16'h0123 -> next cycle bus_out=16'h0123, bus_valid=1; following cycle bus_valid=0, bus_out held.
REQ-033 select=6 with sel_valid=1 -> end_ops=1 next cycle; then select=0 with sel_valid=1 -> bus_out unchanged, no bus_valid; resume=1 -> end_ops=0 next cycle.
REQ-034 select=5 with sel_valid=1 -> bus_out=0, bus_valid=1, sel_err=1, err_count=1.
REQ-035 CNT_W=2, four illegal selects -> err_count reads 1, 2, 3, 3.
REQ-036 In HALT, rst=1 together with sel_valid=1, select=1 -> end_ops=0, bus_out=0, err_count=0, bus_valid=0.
REQ-037 DATA_W=32, NUM_SRC=8, SEL_W=4, END_CODE=15: select=7 loads source 7; select=9 raises sel_err.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus source mux: source codes, halt code, control state.
// Latency: n/a (types and constants only).  Backpressure: n/a.
package bus_pkg;

    typedef enum logic [2:0] {
        SRC_AC = 3'd0,
        SRC_AR = 3'd1,
        SRC_PC = 3'd2,
        SRC_DR = 3'd3,
        SRC_TR = 3'd4
    } src_code_e;

    localparam int END_CODE_DEF = 6;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/bus_err_counter.sv
// Saturating event counter for illegal bus selects.
// Latency: count reflects inc one cycle later.  Backpressure: none; sticks at all-ones.
module bus_err_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/bus_src_mux.sv
// Selects one source register onto bus A, with a HALT state entered by the end code.
// Latency: 1 cycle select-to-bus_out.  Backpressure: none; selects ignored while halted.
module bus_src_mux
    import bus_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_SRC  = 5,
    parameter int SEL_W    = 3,
    parameter int END_CODE = END_CODE_DEF,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sel_valid,
    input  logic [SEL_W-1:0]          select,
    input  logic [NUM_SRC*DATA_W-1:0] src_bus,
    input  logic                      resume,
    output logic [DATA_W-1:0]         bus_out,
    output logic                      bus_valid,
    output logic                      end_ops,
    output logic                      sel_err,
    output logic [CNT_W-1:0]          err_count
);

    localparam logic [SEL_W:0]   NUM_SRC_C  = (SEL_W+1)'(NUM_SRC);
    localparam logic [SEL_W-1:0] END_CODE_C = SEL_W'(END_CODE);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [DATA_W-1:0]   r_bus_out;
    logic                r_bus_valid;
    logic                r_sel_err;
    logic                w_accept;
    logic                w_is_src;
    logic                w_is_end;
    logic                w_load;
    logic                w_err;
    logic                w_end_ops;
    logic [DATA_W-1:0]   w_bus_nxt;

    assign w_accept  = sel_valid && (r_state == ST_RUN);
    assign w_is_src  = ({1'b0, select} < NUM_SRC_C);
    assign w_is_end  = !w_is_src && (select == END_CODE_C);
    assign w_load    = w_accept && !w_is_end;
    assign w_err     = w_accept && !w_is_src && !w_is_end;
    // Illegal codes drive an all-zero bus rather than an out-of-range slice.
    assign w_bus_nxt = w_is_src ? src_bus[select*DATA_W +: DATA_W] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (w_accept && w_is_end) w_state_nxt = ST_HALT;
            ST_HALT: if (resume)               w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_end_ops = (r_state == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_out   <= '0;
            r_bus_valid <= 1'b0;
            r_sel_err   <= 1'b0;
        end else begin
            r_bus_valid <= w_load;
            r_sel_err   <= w_err;
            if (w_load) begin
                r_bus_out <= w_bus_nxt;
            end
        end
    end

    bus_err_counter #(
        .CNT_W (CNT_W)
    ) u_err_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_err),
        .count (err_count)
    );

    assign bus_out   = r_bus_out;
    assign bus_valid = r_bus_valid;
    assign sel_err   = r_sel_err;
    assign end_ops   = w_end_ops;

endmodule

// File: tb/tb_bus_src_mux.sv
// Randomized scoreboard bench for bus_src_mux: default build plus a wide build
// (32-bit data, 8 sources, 4-bit select, end code 15, 2-bit error counter).
module tb_bus_src_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst0, rst1, sv, res;
    logic [2:0]   sel0;
    logic [3:0]   sel1;
    logic [79:0]  src0;
    logic [255:0] src1;

    logic [15:0]  bo0;
    logic         bv0, eo0, se0;
    logic [7:0]   ec0;
    logic [31:0]  bo1;
    logic         bv1, eo1, se1;
    logic [1:0]   ec1;

    bus_src_mux u_dut0 (
        .clk(clk), .rst(rst0), .sel_valid(sv), .select(sel0), .src_bus(src0),
        .resume(res), .bus_out(bo0), .bus_valid(bv0), .end_ops(eo0),
        .sel_err(se0), .err_count(ec0)
    );

    bus_src_mux #(
        .DATA_W(32), .NUM_SRC(8), .SEL_W(4), .END_CODE(15), .CNT_W(2)
    ) u_dut1 (
        .clk(clk), .rst(rst1), .sel_valid(sv), .select(sel1), .src_bus(src1),
        .resume(res), .bus_out(bo1), .bus_valid(bv1), .end_ops(eo1),
        .sel_err(se1), .err_count(ec1)
    );

    typedef struct {
        int          dut;
        logic [31:0] bus;
        logic        vld;
        logic        err;
        logic        halt;
        logic [7:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state and the configuration of the build being exercised
    bit          m_halt;
    logic [31:0] m_bus;
    int          m_cnt;
    int          c_nsrc, c_end, c_cmax;
    logic [31:0] c_mask;
    int          active;
    logic [31:0] src[8];
    bit          hold_src;

    task automatic cyc(input bit r, input bit v, input int s, input bit rs);
        exp_t e;
        @(negedge clk);
        if (!hold_src) begin
            for (int k = 0; k < 8; k++) src[k] = $urandom;
        end
        for (int k = 0; k < 5; k++) src0[k*16 +: 16] = src[k][15:0];
        for (int k = 0; k < 8; k++) src1[k*32 +: 32] = src[k];
        sv   = v;
        res  = rs;
        sel0 = s[2:0];
        sel1 = s[3:0];
        rst0 = (active == 0) ? r : 1'b1;
        rst1 = (active == 1) ? r : 1'b1;

        e.vld = 1'b0;
        e.err = 1'b0;
        if (r) begin
            m_halt = 1'b0;
            m_bus  = '0;
            m_cnt  = 0;
        end else if (!m_halt) begin
            if (v) begin
                if (s < c_nsrc) begin
                    m_bus = src[s] & c_mask;
                    e.vld = 1'b1;
                end else if (s == c_end) begin
                    m_halt = 1'b1;
                end else begin
                    m_bus = '0;
                    e.vld = 1'b1;
                    e.err = 1'b1;
                    if (m_cnt < c_cmax) m_cnt = m_cnt + 1;
                end
            end
        end else if (rs) begin
            m_halt = 1'b0;
        end
        e.dut  = active;
        e.bus  = m_bus;
        e.halt = m_halt;
        e.cnt  = 8'(m_cnt);
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] a_bus;
        logic        a_vld, a_err, a_halt;
        logic [7:0]  a_cnt;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.dut == 0) begin
                    a_bus = {16'h0, bo0}; a_vld = bv0; a_err = se0; a_halt = eo0; a_cnt = ec0;
                end else begin
                    a_bus = bo1; a_vld = bv1; a_err = se1; a_halt = eo1; a_cnt = {6'h0, ec1};
                end
                checks++;
                if (a_bus !== e.bus || a_vld !== e.vld || a_err !== e.err ||
                    a_halt !== e.halt || a_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL outputs dut%0d t=%0t got bus=%h vld=%b err=%b end=%b cnt=%0d expected bus=%h vld=%b err=%b end=%b cnt=%0d",
                             e.dut, $time, a_bus, a_vld, a_err, a_halt, a_cnt,
                             e.bus, e.vld, e.err, e.halt, e.cnt);
                end
            end
        end
    end

    initial begin : driver
        rst0 = 1'b1; rst1 = 1'b1; sv = 1'b0; res = 1'b0;
        sel0 = '0; sel1 = '0; src0 = '0; src1 = '0;
        m_halt = 1'b0; m_bus = '0; m_cnt = 0; hold_src = 1'b0;
        for (int k = 0; k < 8; k++) src[k] = '0;

        active = 0; c_nsrc = 5; c_end = 6; c_cmax = 255; c_mask = 32'h0000_FFFF;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        hold_src = 1'b1;
        src[2] = 32'h0000_0123;
        cyc(0, 1, 2, 0);
        cyc(0, 0, 0, 0);
        hold_src = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 1, 6, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 1, 1);
        cyc(0, 1, 5, 0);
        cyc(0, 1, 7, 0);
        cyc(0, 1, 6, 0);
        cyc(1, 1, 1, 0);
        cyc(0, 1, 3, 0);
        cyc(0, 1, 6, 0);
        cyc(0, 1, 2, 1);
        cyc(0, 1, 4, 0);
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
        end

        active = 1; c_nsrc = 8; c_end = 15; c_cmax = 3; c_mask = 32'hFFFF_FFFF;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 7, 0);
        cyc(0, 1, 9, 0);
        cyc(0, 1, 9, 0);
        cyc(0, 1, 12, 0);
        cyc(0, 1, 9, 0);
        cyc(0, 1, 15, 0);
        cyc(0, 1, 7, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
